// File: rtl/varredura_controle.sv
// rtl/varredura_controle.sv - turret sweep sequencer: dwell, measure, evaluate, lock
module varredura_controle #(
    parameter int DWELL     = 4,
    parameter int W_DWELL   = 22,
    parameter int TIMEOUT   = 10,
    parameter int W_TO      = 24,
    parameter int LOCK_HITS = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ligar,
    input  logic       parar,
    input  logic       destrava,
    input  logic       medida_pronto,
    input  logic       detectado,
    output logic       conta,
    output logic       zera,
    output logic       mede,
    output logic       travado,
    output logic       erro_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        ESPERA  = 3'd2,
        MEDE    = 3'd3,
        AGUARDA = 3'd4,
        AVALIA  = 3'd5,
        AVANCA  = 3'd6,
        TRAVADO = 3'd7
    } state_t;

    localparam logic [W_DWELL-1:0] DWELL_LAST = W_DWELL'(DWELL - 1);
    localparam logic [W_TO-1:0]    TO_LAST    = W_TO'(TIMEOUT - 1);
    localparam logic [3:0]         HITS_LOCK  = 4'(LOCK_HITS);

    state_t             state_q, state_d;
    logic [W_DWELL-1:0] dwell_q, dwell_d;
    logic [W_TO-1:0]    to_q, to_d;
    logic [3:0]         hits_q, hits_d;
    logic               erro_q, erro_d;
    logic               det_q, det_d;
    logic [3:0]         hits_inc;

    assign hits_inc = hits_q + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INICIAL;
            dwell_q <= '0;
            to_q    <= '0;
            hits_q  <= '0;
            erro_q  <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            to_q    <= to_d;
            hits_q  <= hits_d;
            erro_q  <= erro_d;
            det_q   <= det_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        to_d    = to_q;
        hits_d  = hits_q;
        erro_d  = erro_q;
        det_d   = det_q;

        case (state_q)
            INICIAL: begin
                if (ligar && !parar) begin
                    state_d = PREPARA;
                    erro_d  = 1'b0;
                end
            end
            PREPARA: begin
                hits_d  = '0;
                state_d = ESPERA;
            end
            ESPERA: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    state_d = MEDE;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            MEDE: state_d = AGUARDA;
            AGUARDA: begin
                // A response arriving on the last timeout cycle still counts as valid
                if (medida_pronto) begin
                    det_d   = detectado;
                    to_d    = '0;
                    state_d = AVALIA;
                end else if (to_q == TO_LAST) begin
                    erro_d  = 1'b1;
                    det_d   = 1'b0;
                    to_d    = '0;
                    state_d = AVALIA;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            AVALIA: begin
                if (det_q) begin
                    hits_d  = hits_inc;
                    state_d = (hits_inc == HITS_LOCK) ? TRAVADO : ESPERA;
                end else begin
                    hits_d  = '0;
                    state_d = AVANCA;
                end
            end
            AVANCA: state_d = ESPERA;
            TRAVADO: begin
                if (destrava) begin
                    hits_d  = '0;
                    state_d = AVANCA;
                end
            end
            default: state_d = INICIAL;
        endcase

        // Abort keeps the position and the sticky error so the operator can inspect them
        if (parar && state_q != INICIAL) begin
            state_d = INICIAL;
            hits_d  = '0;
            dwell_d = '0;
            to_d    = '0;
            erro_d  = erro_q;
        end
    end

    assign zera         = (state_q == PREPARA);
    assign mede         = (state_q == MEDE);
    assign conta        = (state_q == AVANCA);
    assign travado      = (state_q == TRAVADO);
    assign erro_timeout = erro_q;
    assign db_estado    = {1'b0, state_q};

endmodule

// File: doc/varredura_controle.md
Name: varredura_controle

Overview:
- Sequencing FSM for the turret sweep datapath. Drives the up/down position counter (advance/clear) that positions the servo, waits a servo settling dwell at each position, then triggers one distance measurement and evaluates the result.
- Locks onto a target after LOCK_HITS consecutive detections at the same position.
- Sits between the top-level user controls and the position counter / ultrasonic measurement unit.

Parameters:
DWELL, 4, servo settling time in clock cycles per position (>=1)
W_DWELL, 22, width of dwell counter (2**W_DWELL > DWELL)
TIMEOUT, 10, max cycles waiting for medida_pronto (>=1)
W_TO, 24, width of timeout counter (2**W_TO > TIMEOUT)
LOCK_HITS, 2, consecutive detections required to lock (1..15)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ligar  in  1  start sweep (level, sampled in INICIAL)
parar  in  1  abort to INICIAL from any state
destrava  in  1  release lock, resume sweep (sampled in TRAVADO)
medida_pronto  in  1  measurement unit done pulse
detectado  in  1  target in range; valid on the cycle medida_pronto=1
conta  out  1  one-cycle advance pulse to position counter
zera  out  1  one-cycle synchronous clear to position counter
mede  out  1  one-cycle measurement trigger
travado  out  1  target locked
erro_timeout  out  1  sticky: at least one measurement timed out since last ligar
db_estado  out  4  current state code

Behaviour:
- reset_n=0: state INICIAL, all outputs 0, dwell/timeout counters 0, hit counter 0, erro_timeout 0, det_reg 0. Reset mid-operation aborts immediately, with no residual pulses.
- conta, zera, mede, travado are Moore outputs decoded from the state register only, so they are glitch-free and asserted exactly one cycle per pulse state.
- States and codes:
  - INICIAL(0): idle. ligar=1 and parar=0 -> PREPARA, which also clears erro_timeout.
  - PREPARA(1): zera=1; hit counter <= 0 -> ESPERA.
  - ESPERA(2): dwell counter counts 0..DWELL-1; exits to MEDE when count==DWELL-1, so the state lasts exactly DWELL cycles. Counter clears on exit.
  - MEDE(3): mede=1 -> AGUARDA.
  - AGUARDA(4):
    - medida_pronto=1 -> det_reg <= detectado; go to AVALIA.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without medida_pronto, erro_timeout <= 1, det_reg <= 0, go to AVALIA.
    - medida_pronto wins over a simultaneous timeout.
    - Timeout counter clears on exit.
  - AVALIA(5):
    - det_reg=1: hits <= hits+1. If hits+1==LOCK_HITS -> TRAVADO, else -> ESPERA (re-measure same position, no conta).
    - det_reg=0: hits <= 0 -> AVANCA.
  - AVANCA(6): conta=1 -> ESPERA.
  - TRAVADO(7): travado=1; holds position. destrava=1 -> hits <= 0, go to AVANCA.
- parar=1 in any state other than INICIAL -> INICIAL at next edge; it overrides every other transition. Position counter is not cleared (zera not pulsed); hits, dwell and timeout counters are cleared; erro_timeout is kept.
- ligar and parar both 1 in INICIAL: stay in INICIAL.
- ligar is level-sensitive: if still high on return to INICIAL (via parar release), the sweep restarts.
- medida_pronto outside AGUARDA is ignored.
- Sweep direction and end reversal belong to the position counter; this block only issues conta.
- db_estado = state code, zero-extended.
- Per-position latency with no detection (from entering ESPERA): DWELL + 1 + t_resp + 1 + 1 cycles. t_resp = cycles in AGUARDA (1..TIMEOUT).

Test Plan:
- Reset/start: reset_n low then high, ligar=1 for 1 cycle -> zera=1 exactly one cycle after ligar, then 4 cycles ESPERA, mede=1 one cycle; db_estado sequence 0,1,2,2,2,2,3,4.
- No target: medida_pronto=1, detectado=0 two cycles after mede -> AVALIA, then conta=1 one cycle, then ESPERA again; no travado. Repeat 5 positions -> exactly 5 conta pulses.
- Lock: detectado=1 on two consecutive measurements -> no conta between them; travado=1 from the cycle after the second AVALIA and held 20 cycles. destrava=1 -> travado=0, conta=1 next cycle.
- Broken streak: detectado=1 then 0 -> hits reset; a subsequent single detection does not lock (LOCK_HITS=2).
- Timeout: no medida_pronto for 10 cycles in AGUARDA -> erro_timeout=1, treated as no detection (conta pulse). Late medida_pronto in ESPERA ignored. Next ligar from INICIAL clears erro_timeout.
- Abort/reset: parar=1 during ESPERA, then during AGUARDA -> db_estado=0 next cycle, no zera/conta/mede emitted. reset_n=0 asynchronously mid-AGUARDA -> all outputs 0 immediately, without waiting for a clock edge.
